// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: bytes queued through a small FIFO are serialised as
// 11-bit frames (start, 8 data LSB first, odd parity, stop) on self-generated clk/data.
module ps2_device_tx #(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_AW    = 3,
  parameter int GAP_HALVES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [7:0]         i_wr_data,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  input  logic               i_inhibit,
  output logic               o_ps2_clk,
  output logic               o_ps2_data,
  output logic               o_busy,
  output logic [FIFO_AW:0]   o_level
);

  localparam int DEPTH    = 2 ** FIFO_AW;
  // A zero-length gap still costs the one cycle spent passing through GAP.
  localparam int GAP_CYC  = (GAP_HALVES * CLK_DIV > 0) ? GAP_HALVES * CLK_DIV : 1;
  localparam int CNT_MAX  = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
  localparam int CNT_W    = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT_HIGH,
    S_BIT_LOW,
    S_GAP
  } state_t;

  logic [7:0]       r_mem [DEPTH];
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit_idx;
  logic [10:0]      r_shreg;
  logic             r_ps2_clk;
  logic             r_ps2_data;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [3:0]       w_bit_idx_next;
  logic [10:0]      w_shreg_next;
  logic             w_ps2_clk_next;
  logic             w_ps2_data_next;

  logic [FIFO_AW:0] w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_head;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == (FIFO_AW + 1)'(DEPTH));
  assign w_empty = (w_level == '0);
  assign w_push  = i_wr_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  // Storage carries no reset so it maps onto plain memory; contents are don't-care when empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_wr_data;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_shreg_next    = r_shreg;
    w_ps2_clk_next  = r_ps2_clk;
    w_ps2_data_next = r_ps2_data;
    w_pop           = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ps2_clk_next  = 1'b1;
        w_ps2_data_next = 1'b1;
        if (!w_empty && !i_inhibit) begin
          w_pop           = 1'b1;
          w_shreg_next    = {1'b1, ~^w_head, w_head, 1'b0};
          w_ps2_data_next = 1'b0;
          w_bit_idx_next  = '0;
          w_cnt_next      = '0;
          w_state_next    = S_BIT_HIGH;
        end
      end
      S_BIT_HIGH: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next     = '0;
          w_ps2_clk_next = 1'b0;
          w_state_next   = S_BIT_LOW;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_BIT_LOW: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next     = '0;
          w_ps2_clk_next = 1'b1;
          if (r_bit_idx == 4'd10) begin
            w_ps2_data_next = 1'b1;
            w_state_next    = S_GAP;
          end else begin
            // Data moves on the rising clock edge, a full half-period before the next fall.
            w_shreg_next    = {1'b1, r_shreg[10:1]};
            w_ps2_data_next = r_shreg[1];
            w_bit_idx_next  = r_bit_idx + 1'b1;
            w_state_next    = S_BIT_HIGH;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shreg    <= '1;
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shreg    <= w_shreg_next;
      r_ps2_clk  <= w_ps2_clk_next;
      r_ps2_data <= w_ps2_data_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign o_wr_ready = !w_full;
  assign o_ps2_clk  = r_ps2_clk;
  assign o_ps2_data = r_ps2_data;
  assign o_busy     = (r_state != S_IDLE) || !w_empty;
  assign o_level    = w_level;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Scoreboard bench for ps2_device_tx: writes push expected bytes, a line monitor decodes
// frames at ps2_clk falls and compares them with frames built from the byte.
module tb_ps2_device_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_AW    = 3;
  localparam int GAP_HALVES = 2;
  localparam int DEPTH      = 2 ** FIFO_AW;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic             inhibit = 1'b0;
  logic             ps2_clk;
  logic             ps2_data;
  logic             busy;
  logic [FIFO_AW:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];

  ps2_device_tx #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_AW   (FIFO_AW),
    .GAP_HALVES(GAP_HALVES)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_wr_data (wr_data),
    .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready),
    .i_inhibit (inhibit),
    .o_ps2_clk (ps2_clk),
    .o_ps2_data(ps2_data),
    .o_busy    (busy),
    .o_level   (level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Line monitor: samples on the falling system clock, away from the DUT's update edge.
  int         cyc = 0;
  logic       prev_clk = 1'b1;
  logic       prev_data = 1'b1;
  int         nbits = 0;
  logic [10:0] got_bits;
  logic [10:0] exp_bits;
  logic [7:0] exp_byte;
  logic       frame_done = 1'b0;
  int         t_rise = -1;
  int         last_gap = -1;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      nbits      = 0;
      prev_clk   = 1'b1;
      prev_data  = 1'b1;
      frame_done = 1'b0;
      t_rise     = -1;
    end else begin
      if (!prev_clk && !ps2_clk && (ps2_data != prev_data)) begin
        n_fail++;
        $display("FAIL data_stable: ps2_data changed to %0b while ps2_clk low at cycle %0d", ps2_data, cyc);
      end
      if (prev_clk && !ps2_clk) begin
        got_bits[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame: got unexpected frame %b, expected no frame", got_bits);
          end else begin
            exp_byte     = exp_q.pop_front();
            exp_bits[0]  = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[1+i] = exp_byte[i];
            exp_bits[9]  = ($countones(exp_byte) % 2 == 0);
            exp_bits[10] = 1'b1;
            if (got_bits != exp_bits) begin
              n_fail++;
              $display("FAIL frame: got bits %b, expected %b (byte 0x%02h)", got_bits, exp_bits, exp_byte);
            end else begin
              $display("[TB] frame byte 0x%02h bits %b ok", exp_byte, got_bits);
            end
          end
          nbits      = 0;
          frame_done = 1'b1;
        end
      end
      if (!prev_clk && ps2_clk && frame_done) begin
        t_rise     = cyc;
        frame_done = 1'b0;
      end
      if (prev_data && !ps2_data && ps2_clk && nbits == 0 && t_rise >= 0) begin
        last_gap = cyc - t_rise;
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  task automatic write_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    wr_data  = b;
    wr_valid = 1'b1;
    t = 0;
    while (!wr_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (!wr_ready) begin
      n_fail++;
      $display("FAIL write_timeout: byte 0x%02h not accepted, wr_ready %0b, expected 1", b, wr_ready);
      wr_valid = 1'b0;
      return;
    end
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    $display("[TB] write 0x%02h accepted, level %0d", b, level);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", int'(exp_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    // Reset state while held in reset.
    #23;
    check("rst_ps2_clk", int'(ps2_clk), 1);
    check("rst_ps2_data", int'(ps2_data), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(level), 0);
    check("rst_wr_ready", int'(wr_ready), 1);
    #4;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte: latency of level, start bit and first falling clock.
    wr_data  = 8'h1C;
    wr_valid = 1'b1;
    exp_q.push_back(8'h1C);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check("lat_level_T1", int'(level), 1);
    check("lat_data_T1", int'(ps2_data), 1);
    @(posedge clk);
    #1;
    check("lat_start_T2", int'(ps2_data), 0);
    check("lat_busy", int'(busy), 1);
    repeat (CLK_DIV - 1) @(posedge clk);
    #1;
    check("lat_clk_high", int'(ps2_clk), 1);
    @(posedge clk);
    #1;
    check("lat_clk_fall", int'(ps2_clk), 0);
    wait_drain();
    check("idle_busy", int'(busy), 0);

    // Parity corner bytes.
    write_byte(8'h00);
    write_byte(8'hFF);
    wait_drain();

    // Full FIFO under inhibit; ninth write waits until a slot frees.
    @(negedge clk);
    inhibit = 1'b1;
    for (int i = 1; i <= DEPTH; i++) write_byte(8'(i));
    @(negedge clk);
    check("full_level", int'(level), DEPTH);
    check("full_wr_ready", int'(wr_ready), 0);
    fork
      write_byte(8'h09);
      begin
        repeat (20) @(negedge clk);
        check("inhibit_holds_level", int'(level), DEPTH);
        check("inhibit_no_busy_frame", int'(ps2_clk & ps2_data), 1);
        inhibit = 1'b0;
      end
    join
    wait_drain();

    // Gap between back-to-back frames.
    @(negedge clk);
    inhibit = 1'b1;
    write_byte(8'hA5);
    write_byte(8'h3C);
    @(negedge clk);
    inhibit = 1'b0;
    wait_drain();
    check("gap_cycles", last_gap, GAP_HALVES * CLK_DIV + 1);

    // Reset during data bit 4 of 0xAA.
    write_byte(8'hAA);
    begin
      int t;
      t = 0;
      while (nbits != 5 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      check("reach_bit4", nbits, 5);
    end
    repeat (CLK_DIV + 2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("amid_ps2_clk", int'(ps2_clk), 1);
    check("amid_ps2_data", int'(ps2_data), 1);
    check("amid_level", int'(level), 0);
    check("amid_busy", int'(busy), 0);
    check("amid_wr_ready", int'(wr_ready), 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b1;
    write_byte(8'h55);
    wait_drain();

    // Randomised traffic with inhibit pulses.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        inhibit = 1'b1;
        repeat ($urandom_range(1, 40)) @(negedge clk);
        inhibit = 1'b0;
      end
      write_byte(8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();
    check("final_level", int'(level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_device_tx.md
# ps2_device_tx

Device-side PS/2 transmitter: it plays the keyboard end of the PS/2 link, so it generates both `ps2_clk` and `ps2_data`. Bytes are queued through a valid/ready write port into an internal FIFO. Each byte is serialised as an 11-bit PS/2 frame: start 0, 8 data bits LSB first, odd parity, stop 1. The block drives the on-chip `keyboard` receiver in simulation and loopback tests, and serves as the scan-code source for the NPC keyboard model.

## Interface
- `CLK_DIV`, default 8: system clocks per PS/2 half-period. Must be ≥ 4, so that the receiver's 3-stage synchroniser sees every edge.
- `FIFO_AW`, default 3: FIFO address width; depth is 2**FIFO_AW.
- `GAP_HALVES`, default 2: idle half-periods (both lines high) inserted after every frame.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_data`  in  8  byte to transmit.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  FIFO not full. A write is accepted on a cycle where `wr_valid && wr_ready`.
- `inhibit`  in  1  when high, no new frame starts. A frame already in progress completes.
- `ps2_clk`  out  1  PS/2 clock, registered; idle high.
- `ps2_data`  out  1  PS/2 data, registered; idle high.
- `busy`  out  1  high when state ≠ IDLE or the FIFO is non-empty.
- `level`  out  FIFO_AW+1  current FIFO occupancy.

## Operation
- **FIFO**
  - Write and read pointers are FIFO_AW+1 bits wide. full = level == 2**FIFO_AW; empty = level == 0.
  - `wr_ready` = !full, derived combinationally from registered state.
  - A write and a pop may occur in the same cycle; level is then unchanged.
  - Pointers wrap modulo 2**(FIFO_AW+1).
- **State machine**: IDLE, BIT_HIGH, BIT_LOW, GAP.
- **IDLE**
  - Both lines are high.
  - If the FIFO is non-empty and `inhibit` is 0: pop the head byte and load shift register {1, ~^byte, byte, 0}.
  - Drive `ps2_data` <= 0 (start bit), clear bit_idx and the half-period counter, go to BIT_HIGH.
- **BIT_HIGH**
  - `ps2_clk` stays 1 for CLK_DIV cycles.
  - On the last of those cycles, `ps2_clk` <= 0 and go to BIT_LOW.
- **BIT_LOW**
  - `ps2_clk` stays 0 for CLK_DIV cycles.
  - On the last of those cycles, `ps2_clk` <= 1.
  - If bit_idx == 10: `ps2_data` <= 1 and go to GAP.
  - Otherwise: shift, `ps2_data` <= next bit, bit_idx++, go to BIT_HIGH.
  - `ps2_data` therefore changes only while `ps2_clk` is high and is stable CLK_DIV cycles before each falling edge.
- **GAP**
  - Both lines stay high for GAP_HALVES*CLK_DIV cycles, then go to IDLE.
- **Parity**: the parity bit is odd parity, ~^data. The data bits plus the parity bit always contain an odd number of ones.
- **Asynchronous reset (`reset_n` = 0)**
  - State → IDLE, pointers → 0, FIFO contents are discarded.
  - `ps2_clk` = 1, `ps2_data` = 1, `busy` = 0, `level` = 0, `wr_ready` = 1.
  - A frame interrupted mid-transmission is abandoned: both lines go high immediately and no stop bit is emitted.
- **`inhibit`** is sampled only in IDLE. Raising it mid-frame or mid-GAP has no effect until the block returns to IDLE.

## Timing
- Write accepted in cycle T with the FIFO empty and the block idle:
  - `level` = 1 at T+1.
  - Pop occurs at T+1.
  - `ps2_data` = 0 (start bit) from T+2.
  - First `ps2_clk` falling edge at T+2+CLK_DIV.
- Frame duration, from start-bit data going low to the final `ps2_clk` rise: 22*CLK_DIV cycles.
- Back-to-back frames: the final `ps2_clk` rise at cycle t is followed by the next start bit at t+GAP_HALVES*CLK_DIV+1.
- Throughput: one byte per 22*CLK_DIV + GAP_HALVES*CLK_DIV + 1 cycles.
- `busy` falls in the cycle the block re-enters IDLE with the FIFO empty.

## Test plan
- **Single byte, odd-count data**: CLK_DIV=4, write 0x1C.
  - Bits sampled at `ps2_clk` falls: 0, 0,0,1,1,1,0,0,0, parity 0, stop 1.
  - Start bit appears 2 cycles after the write.
- **Even-ones / zero byte**: write 0x00 → parity bit 1. Write 0xFF → parity bit 1.
- **Full FIFO and inhibit**:
  - Hold `inhibit`=1 and write 9 bytes 0x01..0x09.
  - `wr_ready` drops after the 8th write and 0x09 is held; `level` = 8.
  - Release `inhibit`: frames emerge in order 0x01..0x08, then 0x09 is accepted once `level` < 8.
- **Gap timing**: CLK_DIV=4, GAP_HALVES=2, two queued bytes → exactly 9 cycles from the final `ps2_clk` rise of frame 1 to `ps2_data` falling for frame 2.
- **Reset mid-frame**:
  - Assert `reset_n`=0 during data bit 4 of 0xAA.
  - Both lines go high asynchronously; `level`=0, `busy`=0.
  - After release, a new write of 0x55 transmits a correct, complete frame.
- **Loopback with `keyboard`**:
  - Send 0xF0, 0x1C, 0x5A (CLK_DIV=8).
  - The receiver presents 0xF0, 0x1C, 0x5A in order with `overflow`=0 and no parity rejects.
